// File: rtl/hazard_control_unit.sv
//==============================================================================
// Module      : hazard_control_unit
// Description : Pipeline flow control. Handles load-use bubbles, EX redirects
//               and multi-cycle mul/div stall sequencing. Optional perf
//               counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic                  ex_valid_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_muldiv_i,
    input  logic                  ex_redirect_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  md_busy_o
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_events_o
`endif
);

    localparam int                    c_MD_CNT_W = $clog2(MD_LATENCY + 1);
    localparam logic [c_MD_CNT_W-1:0] c_MD_LOAD  = c_MD_CNT_W'(MD_LATENCY - 2);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [c_MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic w_lu;
    logic w_md_start;
    logic w_md_stall;
    logic w_redir;
    logic w_lu_stall;

    assign w_lu = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                  ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    // Only IDLE may launch a sequence, so the op still sitting in EX during DONE cannot retrigger.
    assign w_md_start = (state_q == c_ST_IDLE) && ex_valid_i && ex_muldiv_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_md_start) begin
                    state_d  = c_ST_BUSY;
                    md_cnt_d = c_MD_LOAD;
                end
            end
            c_ST_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d = c_ST_DONE;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // Mul/div stall dominates; otherwise a redirect wins over a load-use bubble.
    always_comb begin
        w_md_stall     = (state_q == c_ST_BUSY) || w_md_start;
        w_redir        = ex_valid_i && ex_redirect_i && !w_md_stall;
        w_lu_stall     = w_lu && !w_md_stall && !w_redir;
        pc_stall_o     = !rst && (w_md_stall || w_lu_stall);
        if_id_stall_o  = !rst && (w_md_stall || w_lu_stall);
        if_id_flush_o  = !rst && w_redir;
        id_ex_stall_o  = !rst && w_md_stall;
        id_ex_flush_o  = !rst && (w_redir || w_lu_stall);
        ex_mem_flush_o = !rst && w_md_stall;
        md_busy_o      = !rst && ((state_q != c_ST_IDLE) || w_md_start);
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (if_id_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
//==============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed vector bench for hazard_control_unit (MD_LATENCY=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_control_unit;

    localparam int REG_ADDR_W = 5;
    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  id_uses_rs1, id_uses_rs2;
    logic                  ex_valid, ex_mem_read, ex_muldiv, ex_redirect;
    logic                  pc_stall, if_id_stall, if_id_flush;
    logic                  id_ex_stall, id_ex_flush, ex_mem_flush, md_busy;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0]      stall_cycles, flush_events;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .ex_valid_i     (ex_valid),
        .ex_rd_i        (ex_rd),
        .ex_mem_read_i  (ex_mem_read),
        .ex_muldiv_i    (ex_muldiv),
        .ex_redirect_i  (ex_redirect),
        .pc_stall_o     (pc_stall),
        .if_id_stall_o  (if_id_stall),
        .if_id_flush_o  (if_id_flush),
        .id_ex_stall_o  (id_ex_stall),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush),
        .md_busy_o      (md_busy)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events)
`endif
    );

    // Output bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy
    logic [6:0] outs;
    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy};

    localparam logic [6:0] c_NONE  = 7'b000_0000;
    localparam logic [6:0] c_LU    = 7'b110_0100;
    localparam logic [6:0] c_REDIR = 7'b001_0100;
    localparam logic [6:0] c_MDST  = 7'b110_1011;
    localparam logic [6:0] c_MDDN  = 7'b000_0001;

    typedef struct {
        string                 name;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  u1;
        logic                  u2;
        logic                  exv;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mr;
        logic                  redir;
        logic [6:0]            exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input logic [6:0] exp, input string nm);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, outs, exp);
        end
    endtask

    task automatic chk_val(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [6:0] exp, input string nm);
        @(negedge clk);
        chk(exp, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
        ex_muldiv = 1'b0; ex_redirect = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"all_zero",     5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, c_NONE};
        vecs[1] = '{"lu_rs1",       5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, c_LU};
        vecs[2] = '{"lu_rd0_rs1_5", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, c_NONE};
        vecs[3] = '{"lu_rd0_rs1_0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, c_NONE};
        vecs[4] = '{"lu_rs2",       5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, c_LU};
        vecs[5] = '{"rs2_not_used", 5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, c_NONE};
        vecs[6] = '{"lu_ex_invld",  5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, c_NONE};
        vecs[7] = '{"not_load",     5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, c_NONE};
        vecs[8] = '{"redir_over_lu",5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, c_REDIR};
        vecs[9] = '{"redir_invld",  5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, c_NONE};

        // Reset state: outputs forced low even with a mul/div presented
        idle_inputs();
        rst = 1'b1;
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        #3;
        chk(c_NONE, "reset_state");
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_valid = vecs[i].exv; ex_rd = vecs[i].rd;
            ex_mem_read = vecs[i].mr; ex_redirect = vecs[i].redir;
            ex_muldiv = 1'b0;
            cyc(vecs[i].exp, vecs[i].name);
        end
        idle_inputs();
        cyc(c_NONE, "idle_gap");

        // Single mul/div held through DONE; redirect and valid drop inside BUSY are ignored
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        cyc(c_MDST, "md1_stall1");
        ex_redirect = 1'b1;
        cyc(c_MDST, "md1_stall2_redir_ignored");
        ex_redirect = 1'b0; ex_valid = 1'b0;
        cyc(c_MDST, "md1_stall3_valid_drop");
        ex_valid = 1'b1;
        cyc(c_MDST, "md1_stall4");
        cyc(c_MDDN, "md1_done");
        ex_muldiv = 1'b0;
        cyc(c_NONE, "md1_idle_after");

        // Back-to-back: muldiv stays high, second op starts the cycle after DONE
        ex_muldiv = 1'b1;
        for (int k = 0; k < 4; k++) cyc(c_MDST, "b2b_a_stall");
        cyc(c_MDDN, "b2b_a_done");
        for (int k = 0; k < 4; k++) cyc(c_MDST, "b2b_b_stall");
        cyc(c_MDDN, "b2b_b_done");
        ex_muldiv = 1'b0;
        cyc(c_NONE, "b2b_idle");

        // Reset in the 2nd BUSY cycle
        ex_muldiv = 1'b1;
        cyc(c_MDST, "rst_seq_idle_stall");
        cyc(c_MDST, "rst_seq_busy1");
        #1 rst = 1'b1;
        #1 chk(c_NONE, "async_reset_mid_busy");
        @(negedge clk);
        rst = 1'b0;
        #1 chk(c_MDST, "post_rst_stall1");
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) cyc(c_MDST, "post_rst_stall");
        ex_muldiv = 1'b0;
        cyc(c_MDDN, "post_rst_done");
        cyc(c_NONE, "post_rst_idle");

`ifdef HAZARD_PERF_COUNTERS_EN
        // Fresh counters: one mul/div (4 stalls) plus one redirect
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_val(32'(stall_cycles), 32'd0, "perf_reset_stall");
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        for (int k = 0; k < 4; k++) cyc(c_MDST, "perf_md_stall");
        ex_muldiv = 1'b0;
        cyc(c_MDDN, "perf_md_done");
        ex_redirect = 1'b1;
        cyc(c_REDIR, "perf_redir");
        idle_inputs();
        chk_val(32'(stall_cycles), 32'd4, "perf_stall_cycles");
        chk_val(32'(flush_events), 32'd1, "perf_flush_events");
        // Another 4 stall cycles takes the 3-bit counter past 7: saturates
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        for (int k = 0; k < 4; k++) cyc(c_MDST, "perf_md2_stall");
        ex_muldiv = 1'b0;
        cyc(c_MDDN, "perf_md2_done");
        idle_inputs();
        chk_val(32'(stall_cycles), 32'd7, "perf_stall_saturate");
        chk_val(32'(flush_events), 32'd1, "perf_flush_hold");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
